// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: widths, RV64 load encodings,
// FSM state encoding and the alignment legality check.
package load_unit_pkg;

  localparam int XLEN           = 64;
  localparam int CPU_WIDTH      = XLEN;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_ILL = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // A load is illegal when its size does not divide the address or the
  // funct3 has no load meaning; such loads never reach memory.
  function automatic logic load_illegal(input logic [2:0] funct3,
                                        input logic [2:0] addr_lo);
    logic ill;
    ill = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: ill = addr_lo[0];
      F3_LW, F3_LWU: ill = (addr_lo[1:0] != 2'b00);
      F3_LD:         ill = (addr_lo != 3'b000);
      F3_ILL:        ill = 1'b1;
      default:       ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Bundle of the load request, memory read channel and register-file write
// port. The load unit sits on the slave side; the core/memory on the master.
interface load_unit_if;
  import load_unit_pkg::*;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [XLEN-1:0]           ld_addr;
  logic [2:0]                ld_funct3;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [XLEN-1:0]           mem_req_addr;
  logic                      mem_resp_valid;
  logic [XLEN-1:0]           mem_resp_data;

  logic                      reg_wen;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr;
  logic [XLEN-1:0]           reg_wdata;
  logic                      ld_err;

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, ld_rd,
    output ld_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output reg_wen, reg_waddr, reg_wdata, ld_err
  );

  modport master (
    output ld_valid, ld_addr, ld_funct3, ld_rd,
    input  ld_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  reg_wen, reg_waddr, reg_wdata, ld_err
  );

endinterface

// File: rtl/load_align.sv
// Picks the addressed lane out of an aligned 8-byte word and sign- or
// zero-extends it according to the load funct3. Purely combinational so a
// store-to-load forward path can reuse it.
module load_align
  import load_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Move the addressed byte lane down to bit 0, then extend by size/sign.
  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}},         shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}},        shifted[15:0]};
      F3_LWU:  result = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: accepts one load, issues an aligned read,
// waits for the variable-latency response and writes the extended value
// into the register file for one cycle (or pulses ld_err if illegal).
module load_unit
  import load_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  load_unit_if.slave   bus
);

  state_e                    state_q,     state_d;
  logic [XLEN-1:0]           addr_q,      addr_d;
  logic [2:0]                funct3_q,    funct3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [XLEN-1:0]           reg_wdata_q, reg_wdata_d;
  logic [XLEN-1:0]           aligned;

  load_align u_align (
    .funct3 (funct3_q),
    .offset (addr_q[2:0]),
    .data   (bus.mem_resp_data),
    .result (aligned)
  );

  // Next-state logic: latch the request in IDLE, handshake in REQ, capture
  // the response only in WAIT so stray or late responses are dropped.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ld_valid) begin
          addr_d   = bus.ld_addr;
          funct3_d = bus.ld_funct3;
          rd_d     = bus.ld_rd;
          state_d  = load_illegal(bus.ld_funct3, bus.ld_addr[2:0]) ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          reg_wdata_d = aligned;
          reg_waddr_d = rd_q;
          state_d     = ST_WB;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign bus.ld_ready      = (state_q == ST_IDLE) && !rst;
  assign bus.mem_req_valid = (state_q == ST_REQ);
  assign bus.mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign bus.reg_wen       = (state_q == ST_WB) && (rd_q != '0);
  assign bus.reg_waddr     = reg_waddr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.ld_err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected memory requests,
// writebacks and error pulses; a negedge monitor pops and compares them.
module tb_load_unit;
  import load_unit_pkg::*;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic [XLEN-1:0]           wdata;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc_cnt  = 0;
  int   acc_cyc  = 0;
  int   wen_cyc  = 0;

  wb_t             wb_q[$];
  logic [XLEN-1:0] req_q[$];
  bit              err_q[$];

  load_unit_if bus ();

  load_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
    end
  endtask

  // Monitor: every presented output event must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        checks++;
        if (req_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_mem_req actual=0x%016h required=none", bus.mem_req_addr);
        end else begin
          checks--;
          checkOutput("mem_req_addr", bus.mem_req_addr, req_q.pop_front());
        end
      end
      if (bus.reg_wen) begin
        wen_cyc = cyc_cnt;
        checks++;
        if (wb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_reg_wen actual=waddr %0d wdata 0x%016h required=none",
                   bus.reg_waddr, bus.reg_wdata);
        end else begin
          wb_t e;
          checks--;
          e = wb_q.pop_front();
          checkOutput("reg_waddr", 64'(bus.reg_waddr), 64'(e.waddr));
          checkOutput("reg_wdata", bus.reg_wdata, e.wdata);
        end
      end
      if (bus.ld_err) begin
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_ld_err actual=1 required=0");
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!bus.ld_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 64'(bus.ld_ready), 64'd1);
  endtask

  // Issue one load and play the memory side with the given delays.
  task automatic applyStimulus(input logic [63:0] addr, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [63:0] data,
                               input int req_delay, input int resp_delay,
                               input bit expect_err, input logic [63:0] exp_data);
    logic [63:0] exp_addr;
    exp_addr = {addr[63:3], 3'b000};
    @(posedge clk); #1;
    waitIdle("idle_before_load");
    if (expect_err) err_q.push_back(1'b1);
    else begin
      req_q.push_back(exp_addr);
      if (rd != 5'd0) wb_q.push_back('{waddr: rd, wdata: exp_data});
    end
    bus.ld_valid      = 1'b1;
    bus.ld_addr       = addr;
    bus.ld_funct3     = f3;
    bus.ld_rd         = rd;
    bus.mem_req_ready = (req_delay == 0) && !expect_err;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    if (expect_err) begin
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checkOutput("err_no_mem_req", 64'(bus.mem_req_valid), 64'd0);
      checkOutput("err_ready_low", 64'(bus.ld_ready), 64'd0);
      @(negedge clk);
      checkOutput("err_ready_back", 64'(bus.ld_ready), 64'd1);
      checkOutput("err_no_mem_req2", 64'(bus.mem_req_valid), 64'd0);
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
    end else begin
      for (int i = 0; i < req_delay; i++) begin
        @(negedge clk);
        checkOutput("req_valid_held", 64'(bus.mem_req_valid), 64'd1);
        checkOutput("req_addr_stable", bus.mem_req_addr, exp_addr);
        @(posedge clk); #1;
      end
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < resp_delay; i++) begin
        @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = data;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
      waitIdle("idle_after_load");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_addr = '0;
    bus.ld_funct3 = '0;
    bus.ld_rd = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    checkOutput("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("rst_reg_wen", 64'(bus.reg_wen), 64'd0);
    checkOutput("rst_ld_err", 64'(bus.ld_err), 64'd0);
    checkOutput("rst_reg_waddr", 64'(bus.reg_waddr), 64'd0);
    checkOutput("rst_reg_wdata", bus.reg_wdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ld_ready", 64'(bus.ld_ready), 64'd1);

    applyStimulus(64'h8000_0003, F3_LB,  5'd5, 64'h0000_0000_8000_0000, 1, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(64'h8000_0003, F3_LBU, 5'd5, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 64'h0000_0000_0000_0080);
    applyStimulus(64'h8000_0004, F3_LW,  5'd6, 64'h8765_4321_0000_0000, 3, 5, 1'b0, 64'hFFFF_FFFF_8765_4321);
    applyStimulus(64'h8000_0004, F3_LWU, 5'd6, 64'h8765_4321_0000_0000, 3, 5, 1'b0, 64'h0000_0000_8765_4321);
    applyStimulus(64'h8000_0006, F3_LH,  5'd8, 64'hBEEF_0000_0000_0000, 1, 2, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF);
    applyStimulus(64'h8000_0006, F3_LHU, 5'd8, 64'hBEEF_0000_0000_0000, 2, 1, 1'b0, 64'h0000_0000_0000_BEEF);
    applyStimulus(64'h8000_0001, F3_LH,  5'd4, 64'h0, 0, 0, 1'b1, 64'h0);
    applyStimulus(64'h8000_0000, F3_ILL, 5'd4, 64'h0, 0, 0, 1'b1, 64'h0);
    applyStimulus(64'h8000_0002, F3_LW,  5'd4, 64'h0, 0, 0, 1'b1, 64'h0);
    applyStimulus(64'h8000_0004, F3_LD,  5'd4, 64'h0, 0, 0, 1'b1, 64'h0);
    applyStimulus(64'h8000_0010, F3_LD,  5'd0, 64'h5555_AAAA_5555_AAAA, 1, 1, 1'b0, 64'h0);

    // Immediate ready and response: writeback in the third cycle after accept.
    @(posedge clk); #1;
    waitIdle("idle_before_latency");
    req_q.push_back(64'h8000_0010);
    wb_q.push_back('{waddr: 5'd3, wdata: 64'h0123_4567_89AB_CDEF});
    bus.ld_valid = 1'b1;
    bus.ld_addr = 64'h8000_0010;
    bus.ld_funct3 = F3_LD;
    bus.ld_rd = 5'd3;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc_cnt;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_c1_ready", 64'(bus.ld_ready), 64'd0);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    checkOutput("lat_c2_ready", 64'(bus.ld_ready), 64'd0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 64'h0;
    @(negedge clk);
    checkOutput("lat_c3_ready", 64'(bus.ld_ready), 64'd0);
    checkOutput("lat_c3_wen", 64'(bus.reg_wen), 64'd1);
    @(negedge clk);
    checkOutput("lat_c4_ready", 64'(bus.ld_ready), 64'd1);
    checkOutput("lat_c4_wen", 64'(bus.reg_wen), 64'd0);
    checkOutput("lat_distance", 64'(wen_cyc - acc_cyc), 64'd2);

    // Reset while waiting for the response; the late response is dropped.
    @(posedge clk); #1;
    waitIdle("idle_before_reset");
    req_q.push_back(64'h8000_0020);
    bus.ld_valid = 1'b1;
    bus.ld_addr = 64'h8000_0020;
    bus.ld_funct3 = F3_LD;
    bus.ld_rd = 5'd7;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_ready", 64'(bus.ld_ready), 64'd1);
    checkOutput("after_rst_wdata", bus.reg_wdata, 64'd0);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("stray_no_wen", 64'(bus.reg_wen), 64'd0);
    checkOutput("stray_idle", 64'(bus.ld_ready), 64'd1);
    checkOutput("stray_wdata", bus.reg_wdata, 64'd0);

    applyStimulus(64'h8000_0008, F3_LD, 5'd9, 64'h1122_3344_5566_7788, 0, 1, 1'b0, 64'h1122_3344_5566_7788);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("req_queue_empty", 64'(req_q.size()), 64'd0);
    checkOutput("wb_queue_empty", 64'(wb_q.size()), 64'd0);
    checkOutput("err_queue_empty", 64'(err_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
